mux_4_to_1: RTL and testbench
=============================

# mux_4_to_1

Four-input, WIDTH-bit selector with a combinational output and a registered copy. The 2-bit select `S` picks one of data inputs `D1`..`D4`. Intended as a leaf datapath block wherever a small source-select is needed. The combinational output serves same-cycle consumers; the registered output serves timing-critical downstream logic.

## Interface
- `WIDTH`, default 1: bit width of every data input and of both outputs.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `S`  input  2  select code.
- `D1`  input  WIDTH  data, selected when `S`=2'b00.
- `D2`  input  WIDTH  data, selected when `S`=2'b01.
- `D3`  input  WIDTH  data, selected when `S`=2'b10.
- `D4`  input  WIDTH  data, selected when `S`=2'b11.
- `Y`  output  WIDTH  combinational selected data.
- `Y_q`  output  WIDTH  registered selected data.
- `EN`  input  1  register load enable. Present only with `MUX_4_TO_1_HOLD_EN`.

## Operation
- `Y` = `D1` / `D2` / `D3` / `D4` for `S` = 00 / 01 / 10 / 11.
  - Pure combinational: no clock dependency, and not affected by `rst`.
- `S` containing X/Z drives `Y` to all-X in simulation. Synthesis treats this as don't-care.
- `Y_q` loads the current `Y` value on each rising `clk` edge.
- No arithmetic; data passes through bit-for-bit with no width change.

## Timing
- `Y`: zero-cycle latency. It follows any change on `S` or the selected data input within the same delta/propagation time.
- `Y_q`: one-cycle latency. The value at edge n is `Y` sampled at edge n.
- Reset:
  - `rst`=1 at a rising edge sets `Y_q` to 0 (all WIDTH bits).
  - `rst` has priority over `EN` and over data loading.
  - Deasserting `rst` mid-stream means `Y_q` resumes tracking `Y` at the first edge with `rst`=0.
- Before the first reset edge, `Y_q` is undefined. `Y` is valid immediately.
- Simultaneous changes of `S` and data within a cycle: `Y_q` captures the settled values present at the edge.

## Configuration
- `MUX_4_TO_1_HOLD_EN` defined:
  - Port `EN` exists.
  - `Y_q` loads `Y` only on edges where `EN`=1 and `rst`=0.
  - With `EN`=0 it holds its previous value.
- `MUX_4_TO_1_HOLD_EN` undefined:
  - No `EN` port.
  - `Y_q` loads `Y` on every non-reset edge.
- `Y` is identical in both builds.

## Test plan
- Select sweep, WIDTH=1:
  - Stimulus: `D1`=0, `D2`=1, `D3`=0, `D4`=1, with `S`=00, 01, 10, 11, each held 20 ns.
  - Required: `Y`=0, 1, 0, 1, with no clock activity needed.
- Data-follow:
  - Stimulus: `S`=10, toggle `D3` 0→1→0, leave others constant.
  - Required: `Y` mirrors `D3` immediately. Changes on `D1`/`D2`/`D4` cause no `Y` change.
- Register latency:
  - Stimulus: reset, then `D1`..`D4`=0,1,0,1 and step `S` 00→01→10→11 on consecutive edges.
  - Required: `Y_q` = 0, 1, 0, 1, each one cycle after the corresponding `S` step.
- Reset mid-operation:
  - Stimulus: `Y_q`=1 (`S`=01, `D2`=1), assert `rst` for one edge.
  - Required: `Y_q`=0 after that edge, `Y` stays 1. `Y_q` returns to 1 on the next edge after `rst` deasserts.
- Width check, WIDTH=8:
  - Stimulus: `D1`=8'hA5, `D2`=8'h3C, `D3`=8'hFF, `D4`=8'h00, sweep `S`.
  - Required: `Y` = A5, 3C, FF, 00.
- Hold (`MUX_4_TO_1_HOLD_EN` only):
  - Stimulus: `Y_q`=1, drive `EN`=0 and switch `S` to 00 (`D1`=0) for 3 edges.
  - Required: `Y_q` stays 1. `EN`=1 on the next edge gives `Y_q`=0.

Source files
------------

// File: rtl/mux_4_to_1.sv
// mux_4_to_1: WIDTH-bit 4:1 selector with a combinational output Y and a registered copy Y_q.
// Optional build macro MUX_4_TO_1_HOLD_EN adds an EN port that gates loading of Y_q.
module mux_4_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MUX_4_TO_1_HOLD_EN
    input  logic             EN,
`endif
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q
);

    logic [WIDTH-1:0] Y_d;

    // An unknown select falls through to the default and yields all-X in simulation.
    always_comb begin
        Y = {WIDTH{1'bx}};
        case (S)
            2'b00:   Y = D1;
            2'b01:   Y = D2;
            2'b10:   Y = D3;
            2'b11:   Y = D4;
            default: Y = {WIDTH{1'bx}};
        endcase
    end

    always_comb begin
        Y_d = Y;
`ifdef MUX_4_TO_1_HOLD_EN
        if (!EN) begin
            Y_d = Y_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q <= '0;
        end else begin
            Y_q <= Y_d;
        end
    end

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed self-checking bench for mux_4_to_1, instantiating a WIDTH=1 and a WIDTH=8 copy.
// Define MUX_4_TO_1_HOLD_EN for both RTL and bench to exercise the hold feature.
module tb_mux_4_to_1;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] s;
    logic       d1, d2, d3, d4;
    logic       y1, yq1;
    logic [7:0] e1, e2, e3, e4;
    logic [7:0] y8, yq8;

    int n_compared;
    int n_mismatched;

    mux_4_to_1 #(.WIDTH(1)) dut1 (
        .clk(clk),
        .rst(rst),
`ifdef MUX_4_TO_1_HOLD_EN
        .EN(en),
`endif
        .S(s),
        .D1(d1),
        .D2(d2),
        .D3(d3),
        .D4(d4),
        .Y(y1),
        .Y_q(yq1)
    );

    mux_4_to_1 #(.WIDTH(8)) dut8 (
        .clk(clk),
        .rst(rst),
`ifdef MUX_4_TO_1_HOLD_EN
        .EN(en),
`endif
        .S(s),
        .D1(e1),
        .D2(e2),
        .D3(e3),
        .D4(e4),
        .Y(y8),
        .Y_q(yq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_compared++;
        if (yq1 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_yq1: got %b expected 0", yq1);
        end
        n_compared++;
        if (yq8 !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_yq8: got %h expected 00", yq8);
        end
        rst = 1'b0;
    endtask

    task automatic test_select_sweep();
        logic exp_y [4];
        exp_y = '{1'b0, 1'b1, 1'b0, 1'b1};
        d1 = 1'b0; d2 = 1'b1; d3 = 1'b0; d4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = i[1:0];
            #20;
            n_compared++;
            if (y1 !== exp_y[i]) begin
                n_mismatched++;
                $display("[TB] FAIL sweep_s%0d: got %b expected %b", i, y1, exp_y[i]);
            end
        end
    endtask

    task automatic test_data_follow();
        logic exp_y [3];
        exp_y = '{1'b0, 1'b1, 1'b0};
        s = 2'b10;
        d1 = 1'b1; d2 = 1'b0; d4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d3 = exp_y[i];
            #1;
            n_compared++;
            if (y1 !== exp_y[i]) begin
                n_mismatched++;
                $display("[TB] FAIL follow_d3_step%0d: got %b expected %b", i, y1, exp_y[i]);
            end
        end
        // Unselected inputs toggle; Y must stay at D3 = 0.
        d1 = 1'b0; d2 = 1'b1; d4 = 1'b0;
        #1;
        n_compared++;
        if (y1 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL follow_unselected: got %b expected 0", y1);
        end
    endtask

    task automatic test_register_latency();
        logic       exp_q  [4];
        logic [7:0] exp_q8 [4];
        exp_q  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_q8 = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d1 = 1'b0; d2 = 1'b1; d3 = 1'b0; d4 = 1'b1;
        e1 = 8'h11; e2 = 8'h22; e3 = 8'h33; e4 = 8'h44;
        for (int i = 0; i < 4; i++) begin
            s = i[1:0];
            tick();
            n_compared++;
            if (yq1 !== exp_q[i]) begin
                n_mismatched++;
                $display("[TB] FAIL latency_yq1_s%0d: got %b expected %b", i, yq1, exp_q[i]);
            end
            n_compared++;
            if (yq8 !== exp_q8[i]) begin
                n_mismatched++;
                $display("[TB] FAIL latency_yq8_s%0d: got %h expected %h", i, yq8, exp_q8[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        s = 2'b01; d2 = 1'b1;
        tick();
        n_compared++;
        if (yq1 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_pre: got %b expected 1", yq1);
        end
        rst = 1'b1;
        tick();
        n_compared++;
        if (yq1 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_yq: got %b expected 0", yq1);
        end
        n_compared++;
        if (y1 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_y: got %b expected 1", y1);
        end
        rst = 1'b0;
        tick();
        n_compared++;
        if (yq1 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_resume: got %b expected 1", yq1);
        end
    endtask

    task automatic test_width8();
        logic [7:0] exp_y [4];
        exp_y = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        e1 = 8'hA5; e2 = 8'h3C; e3 = 8'hFF; e4 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            s = i[1:0];
            #20;
            n_compared++;
            if (y8 !== exp_y[i]) begin
                n_mismatched++;
                $display("[TB] FAIL width8_s%0d: got %h expected %h", i, y8, exp_y[i]);
            end
        end
    endtask

`ifdef MUX_4_TO_1_HOLD_EN
    task automatic test_hold();
        en = 1'b1;
        s = 2'b01; d1 = 1'b0; d2 = 1'b1;
        tick();
        n_compared++;
        if (yq1 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL hold_setup: got %b expected 1", yq1);
        end
        en = 1'b0;
        s = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++;
            if (yq1 !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL hold_edge%0d: got %b expected 1", i, yq1);
            end
        end
        en = 1'b1;
        tick();
        n_compared++;
        if (yq1 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_release: got %b expected 0", yq1);
        end
        // Reset wins over a deasserted EN.
        s = 2'b01;
        tick();
        en = 1'b0;
        rst = 1'b1;
        tick();
        n_compared++;
        if (yq1 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_rst_priority: got %b expected 0", yq1);
        end
        rst = 1'b0;
        en = 1'b1;
    endtask
`endif

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b0;
        en  = 1'b1;
        s   = 2'b00;
        d1 = 1'b0; d2 = 1'b0; d3 = 1'b0; d4 = 1'b0;
        e1 = 8'h00; e2 = 8'h00; e3 = 8'h00; e4 = 8'h00;
        #2;
        test_reset();
        test_select_sweep();
        test_data_follow();
        test_register_latency();
        test_reset_mid();
        test_width8();
`ifdef MUX_4_TO_1_HOLD_EN
        test_hold();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
